// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational imem, buffers words for decode.
// Latency: a fetched word appears on out_* one cycle after its push (no bypass); one word per cycle.
// Backpressure: out_ready low fills the FIFO and stalls fetch; redirect flushes. Macro IMEM_FETCH_EBREAK_HALT_EN enables ebreak halt.
module imem_fetch_ctrl #(
  parameter int              N        = 32,
  parameter int              ADDR_W   = 6,
  parameter int              PC_W     = 64,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [N-1:0]      imem_q,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   fetch_pc,
  output logic              halted,
  output logic              fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N-1:0]      head_instr_q, head_instr_d;
  logic [PC_W-1:0]   head_pc_q, head_pc_d;

  logic [N-1:0]      fifo_instr [DEPTH];
  logic [PC_W-1:0]   fifo_pc    [DEPTH];

  logic              pop;
  logic              push;
  logic              pc_ok;
  logic              redir_take;
  logic              redir_bad;
  logic              ebreak_push;
  logic [CNT_W-1:0]  cnt_after_pop;

  // Legal byte addresses are those whose bits above the imem word index are zero.
  function automatic logic in_range(input logic [PC_W-1:0] a);
    return a[PC_W-1:ADDR_W+2] == '0;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign pc_ok      = in_range(pc_q);
  assign redir_take = redirect_valid && (state_q != ST_FAULT);
  assign redir_bad  = (redirect_pc[1:0] != 2'b00) || !in_range(redirect_pc);
  assign push       = (state_q == ST_RUN) && !redirect_valid && pc_ok &&
                      ((count_q < CNT_W'(DEPTH)) || pop);

`ifdef IMEM_FETCH_EBREAK_HALT_EN
  localparam logic [N-1:0] EBREAK = N'(32'h0010_0073);
  assign ebreak_push = push && (imem_q == EBREAK);
  assign halted      = (state_q == ST_HALT);
`else
  assign ebreak_push = 1'b0;
  assign halted      = 1'b0;
`endif

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign fetch_pc  = pc_q;
  assign fault     = (state_q == ST_FAULT);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;

  // Occupancy once this cycle's pop (if any) is taken.
  assign cnt_after_pop = count_q - CNT_W'(pop);

  // Next-state: redirect wins over everything; otherwise sequential fetch and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;

    if (redir_take) begin
      // Flush: any simultaneous pop is discarded with the rest; head outputs just hold.
      pc_d     = redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = redir_bad ? ST_FAULT : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!pc_ok)          state_d = ST_FAULT;
          else if (ebreak_push) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (resume) state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase

      if (push) begin
        pc_d     = pc_q + PC_W'(4);
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = cnt_after_pop + CNT_W'(push);

      // Head register tracks the entry at the read pointer; it holds when the FIFO drains.
      if (cnt_after_pop != '0) begin
        head_instr_d = fifo_instr[rd_ptr_d];
        head_pc_d    = fifo_pc[rd_ptr_d];
      end else if (push) begin
        head_instr_d = imem_q;
        head_pc_d    = pc_q;
      end
    end
  end

  // Control and head registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_q] <= imem_q;
      fifo_pc[wr_ptr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: table of per-cycle vectors plus directed corner sequences.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
// Fixed cycle counts throughout; no open-ended waits.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        resume;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] fetch_pc;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [64];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resume         (resume),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fetch_pc       (fetch_pc),
    .halted         (halted),
    .fault          (fault)
  );

  assign imem_q = rom[imem_addr];

  always #5 clk = ~clk;

  // imem image: filler words "addi x0,x0,k" plus the known program words at their addresses.
  initial begin
    for (int k = 0; k < 64; k++) rom[k] = 32'h0000_0013 | (32'(k) << 20);
    rom[0]  = 32'hff01_0113;
    rom[1]  = 32'h0011_3423;
    rom[2]  = 32'h0081_3023;
    rom[38] = 32'hfd01_0113;
    rom[39] = 32'h0211_3423;
    rom[46] = 32'h0010_0073;
    rom[47] = 32'hfe04_3583;
    rom[63] = 32'h0000_0000;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [63:0] ep;
    logic [63:0] efp;
  } vec_t;

  vec_t tbl [15];
  logic [63:0] efp_tmp;

  initial begin
    // Expected outputs are the state before the edge that follows each vector.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         64'h0, 64'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         64'h0, 64'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'hff01_0113, 64'h0, 64'h4};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0011_3423, 64'h4, 64'h8};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0081_3023, 64'h8, 64'hc};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         64'h0, 64'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         64'h0, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         64'h0, 64'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'hff01_0113, 64'h0, 64'h4};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'hff01_0113, 64'h0, 64'h8};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 32'hff01_0113, 64'h0, 64'h8};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'hff01_0113, 64'h0, 64'h8};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h0011_3423, 64'h4, 64'hc};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h0081_3023, 64'h8, 64'h10};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h0030_0013, 64'hc, 64'h14};

    clk            = 1'b0;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resume         = 1'b0;
    out_ready      = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset, streaming with out_ready=1, mid-stream reset, then fill-and-release with out_ready=0.
    for (int i = 0; i < 15; i++) begin
      rst_n     = tbl[i].rst_n;
      out_ready = tbl[i].rdy;
      #1;
      efp_tmp = tbl[i].efp;
      chk($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("v%0d.out_instr", i), 64'(out_instr), 64'(tbl[i].ei));
      chk($sformatf("v%0d.out_pc", i),    out_pc,         tbl[i].ep);
      chk($sformatf("v%0d.fetch_pc", i),  fetch_pc,       tbl[i].efp);
      chk($sformatf("v%0d.imem_addr", i), 64'(imem_addr), 64'(efp_tmp[7:2]));
      chk($sformatf("v%0d.halted", i),    64'(halted),    64'h0);
      chk($sformatf("v%0d.fault", i),     64'(fault),     64'h0);
      step();
    end

    // Fill to full, then redirect to 0x98 while full with a pop offered.
    out_ready = 1'b0;
    step();
    chk("full.out_valid", 64'(out_valid), 64'h1);
    chk("full.out_pc",    out_pc,         64'h10);
    chk("full.fetch_pc",  fetch_pc,       64'h18);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h98;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir.flushed",  64'(out_valid), 64'h0);
    chk("redir.fetch_pc", fetch_pc,       64'h98);
    step();
    chk("redir.first_instr", 64'(out_instr), 64'hfd01_0113);
    chk("redir.first_pc",    out_pc,         64'h98);
    step();
    chk("redir.second_instr", 64'(out_instr), 64'h0211_3423);
    chk("redir.second_pc",    out_pc,         64'h9c);

    // Run through the ebreak at 0xb8.
    redirect_valid = 1'b1;
    redirect_pc    = 64'ha8;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("ebreak.instr",    64'(out_instr), 64'h0010_0073);
    chk("ebreak.pc",       out_pc,         64'hb8);
    chk("ebreak.fetch_pc", fetch_pc,       64'hbc);
`ifdef IMEM_FETCH_EBREAK_HALT_EN
    chk("ebreak.halted", 64'(halted), 64'h1);
    step();
    chk("halt.no_push",  64'(out_valid), 64'h0);
    chk("halt.fetch_pc", fetch_pc,       64'hbc);
    step();
    chk("halt.still_halted", 64'(halted),    64'h1);
    chk("halt.still_empty",  64'(out_valid), 64'h0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume.halted", 64'(halted), 64'h0);
    step();
`else
    chk("ebreak.halted", 64'(halted), 64'h0);
    step();
`endif
    chk("after_ebreak.valid", 64'(out_valid), 64'h1);
    chk("after_ebreak.instr", 64'(out_instr), 64'hfe04_3583);
    chk("after_ebreak.pc",    out_pc,         64'hbc);

    // Misaligned redirect faults; fault is sticky against later redirect and resume.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    step();
    redirect_valid = 1'b0;
    chk("misalign.fault",    64'(fault),     64'h1);
    chk("misalign.fetch_pc", fetch_pc,       64'h102);
    chk("misalign.flushed",  64'(out_valid), 64'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0;
    resume         = 1'b1;
    step();
    redirect_valid = 1'b0;
    resume         = 1'b0;
    step();
    chk("sticky.fault",    64'(fault),     64'h1);
    chk("sticky.fetch_pc", fetch_pc,       64'h102);
    chk("sticky.valid",    64'(out_valid), 64'h0);

    // Reset drops fault without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("arst.fault",    64'(fault), 64'h0);
    chk("arst.fetch_pc", fetch_pc,   64'h0);
    step();

    // Run off the end of imem: push of 0xfc, then fault at 0x100, FIFO still drains.
    rst_n          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hf0;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    chk("end.full_pc", fetch_pc, 64'hf8);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    out_ready = 1'b1;
    step();
    chk("end.pc_past", fetch_pc, 64'h100);
    chk("end.no_fault_yet", 64'(fault), 64'h0);
    out_ready = 1'b0;
    step();
    chk("end.fault",      64'(fault),     64'h1);
    chk("end.fault_pc",   fetch_pc,       64'h100);
    chk("end.valid",      64'(out_valid), 64'h1);
    chk("end.head_instr", 64'(out_instr), 64'h03e0_0013);
    chk("end.head_pc",    out_pc,         64'hf8);
    out_ready = 1'b1;
    step();
    chk("drain.instr", 64'(out_instr), 64'h0);
    chk("drain.pc",    out_pc,         64'hfc);
    chk("drain.valid", 64'(out_valid), 64'h1);
    step();
    chk("drain.empty",     64'(out_valid), 64'h0);
    chk("drain.hold_pc",   out_pc,         64'hfc);
    chk("drain.fault_set", 64'(fault),     64'h1);

    // Reset mid-stream with entries buffered.
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    chk("mid.valid_before", 64'(out_valid), 64'h1);
    chk("mid.pc_before",    fetch_pc,       64'h8);
    rst_n = 1'b0;
    #1;
    chk("mid.valid",     64'(out_valid), 64'h0);
    chk("mid.halted",    64'(halted),    64'h0);
    chk("mid.fault",     64'(fault),     64'h0);
    chk("mid.fetch_pc",  fetch_pc,       64'h0);
    chk("mid.out_instr", 64'(out_instr), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
